// File: rtl/spi_burst_pkg.sv
// Shared opcodes, FSM state encoding and constants for the SPI burst command engine.
package spi_burst_pkg;

    localparam int unsigned OP_RD = 1;
    localparam int unsigned OP_WR = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD_REQ,
        RD_WAIT,
        RD_SHIFT,
        WR_WAIT,
        WR,
        FLUSH
    } state_t;

    // Byte returned to the master when the register file never answers a read.
    localparam logic [63:0] FILL_ONES = '1;

    function automatic logic op_is_valid(input int unsigned op);
        return (op == OP_RD) || (op == OP_WR);
    endfunction

endpackage

// File: rtl/spi_burst_timer.sv
// Saturating cycle counter; expired rises on the LIMIT-th consecutive enabled cycle.
module spi_burst_timer #(
    parameter int LIMIT = 15,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_W'(LIMIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the cycles already spent, so the current cycle is count_reg+1.
    assign expired = enable && (count_reg >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/spi_burst_sm.sv
// SPI command decoder: opcode/length byte, multi-byte address, then an
// auto-incrementing read or write burst with read timeout and chip-select abort.
module spi_burst_sm
    import spi_burst_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 16,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_load,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_rvalid,
    output logic              err_cmd,
    output logic              err_timeout,
    output logic              busy
);

    localparam int ADDR_BYTES = ADDR_W / DATA_W;
    localparam int OP_W       = DATA_W - LEN_W;
    localparam int BCNT_W     = $clog2(ADDR_BYTES + 1);

    state_t              state_reg;
    logic [OP_W-1:0]     op_reg;
    logic [LEN_W-1:0]    remaining_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [BCNT_W-1:0]   bcnt_reg;

    logic [OP_W-1:0]     rx_op;
    logic [LEN_W-1:0]    rx_len;
    logic [ADDR_W-1:0]   addr_shifted;
    logic                timer_clear;
    logic                timer_enable;
    logic                timer_expired;

    assign rx_op    = rx_data[DATA_W-1:LEN_W];
    assign rx_len   = rx_data[LEN_W-1:0];
    assign reg_addr = addr_reg;

    // Address arrives MSB byte first; a single-byte address simply replaces.
    generate
        if (ADDR_BYTES == 1) begin : g_addr_single
            assign addr_shifted = rx_data;
        end else begin : g_addr_multi
            assign addr_shifted = {addr_reg[ADDR_W-DATA_W-1:0], rx_data};
        end
    endgenerate

    assign timer_clear  = (state_reg == RD_REQ);
    assign timer_enable = (state_reg == RD_WAIT);

    spi_burst_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            remaining_reg <= '0;
            addr_reg      <= '0;
            bcnt_reg      <= '0;
            tx_data       <= '0;
            tx_load       <= 1'b0;
            reg_wdata     <= '0;
            reg_we        <= 1'b0;
            reg_re        <= 1'b0;
            err_cmd       <= 1'b0;
            err_timeout   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            tx_load     <= 1'b0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            err_cmd     <= 1'b0;
            err_timeout <= 1'b0;

            // Chip-select loss overrides every transition and suppresses new strobes.
            if (!cs_active) begin
                state_reg <= IDLE;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rx_done) begin
                            op_reg        <= rx_op;
                            remaining_reg <= rx_len;
                            bcnt_reg      <= '0;
                            busy          <= 1'b1;
                            if (op_is_valid(32'(rx_op))) begin
                                state_reg <= ADDR;
                            end else begin
                                state_reg <= FLUSH;
                                err_cmd   <= 1'b1;
                            end
                        end
                    end
                    ADDR: begin
                        if (rx_done) begin
                            addr_reg <= addr_shifted;
                            if (bcnt_reg == BCNT_W'(ADDR_BYTES - 1)) begin
                                if (op_reg == OP_W'(OP_RD)) begin
                                    state_reg <= RD_REQ;
                                    reg_re    <= 1'b1;
                                end else begin
                                    state_reg <= WR_WAIT;
                                end
                            end else begin
                                bcnt_reg <= bcnt_reg + 1'b1;
                            end
                        end
                    end
                    RD_REQ: begin
                        state_reg <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        // Data that shows up on the timeout cycle still wins.
                        if (reg_rvalid) begin
                            tx_data   <= reg_rdata;
                            tx_load   <= 1'b1;
                            state_reg <= RD_SHIFT;
                        end else if (timer_expired) begin
                            tx_data     <= FILL_ONES[DATA_W-1:0];
                            tx_load     <= 1'b1;
                            err_timeout <= 1'b1;
                            state_reg   <= RD_SHIFT;
                        end
                    end
                    RD_SHIFT: begin
                        if (rx_done) begin
                            if (remaining_reg == '0) begin
                                state_reg <= FLUSH;
                            end else begin
                                addr_reg      <= addr_reg + 1'b1;
                                remaining_reg <= remaining_reg - 1'b1;
                                reg_re        <= 1'b1;
                                state_reg     <= RD_REQ;
                            end
                        end
                    end
                    WR_WAIT: begin
                        if (rx_done) begin
                            reg_wdata <= rx_data;
                            reg_we    <= 1'b1;
                            state_reg <= WR;
                        end
                    end
                    WR: begin
                        if (remaining_reg == '0) begin
                            state_reg <= FLUSH;
                        end else begin
                            addr_reg      <= addr_reg + 1'b1;
                            remaining_reg <= remaining_reg - 1'b1;
                            state_reg     <= WR_WAIT;
                        end
                    end
                    FLUSH: begin
                        state_reg <= FLUSH;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_sm.sv
// Self-checking bench for spi_burst_sm: directed frame table, hand-built reset
// sequences and random frames checked against a word-level burst model.
module tb_spi_burst_sm;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_active;
    logic        rx_done;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_rdata;
    logic        reg_rvalid;
    logic        err_cmd;
    logic        err_timeout;
    logic        busy;

    always #5 clk = ~clk;

    spi_burst_sm #(
        .DATA_W  (8),
        .ADDR_W  (16),
        .LEN_W   (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cs_active   (cs_active),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        int          nd;
        int          lat;
        int          ewe;
        int          ere;
        int          ecmd;
        int          eto;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int we_addr_q[$];
    int we_data_q[$];
    int re_q[$];
    int re_cyc_q[$];
    int tx_q[$];
    int tx_cyc_q[$];
    int n_cmd;
    int n_to;

    int         lat;
    int         pend_cnt;
    int         pend_idx;
    logic [7:0] salt;
    logic [7:0] wdat [0:31];

    function automatic logic [7:0] resp(input int k);
        return 8'((k + 1) * 17) ^ salt;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT outputs mid-cycle, then drive the slave's response.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (reg_we) begin
            we_addr_q.push_back(int'(reg_addr));
            we_data_q.push_back(int'(reg_wdata));
        end
        if (tx_load) begin
            tx_q.push_back(int'(tx_data));
            tx_cyc_q.push_back(cyc);
        end
        if (err_cmd) n_cmd++;
        if (err_timeout) n_to++;
        reg_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                reg_rvalid = 1'b1;
                reg_rdata  = resp(pend_idx);
            end
        end
        if (reg_re) begin
            re_q.push_back(int'(reg_addr));
            re_cyc_q.push_back(cyc);
            pend_cnt = lat;
            pend_idx = re_q.size() - 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic clear_capture();
        we_addr_q.delete();
        we_data_q.delete();
        re_q.delete();
        re_cyc_q.delete();
        tx_q.delete();
        tx_cyc_q.delete();
        n_cmd    = 0;
        n_to     = 0;
        pend_cnt = 0;
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_tx_data"}, int'(tx_data), 0);
        check({pfx, "_tx_load"}, int'(tx_load), 0);
        check({pfx, "_reg_addr"}, int'(reg_addr), 0);
        check({pfx, "_reg_wdata"}, int'(reg_wdata), 0);
        check({pfx, "_reg_we"}, int'(reg_we), 0);
        check({pfx, "_reg_re"}, int'(reg_re), 0);
        check({pfx, "_err_cmd"}, int'(err_cmd), 0);
        check({pfx, "_err_timeout"}, int'(err_timeout), 0);
        check({pfx, "_busy"}, int'(busy), 0);
    endtask

    // Word-level expectation: how many writes/reads/errors a frame must yield.
    task automatic model(input logic [7:0] cmd, input int nd, input int l,
                         output int ewe, output int ere, output int ecmd, output int eto);
        int op;
        int words;
        op    = int'(cmd[7:4]);
        words = int'(cmd[3:0]) + 1;
        ewe = 0; ere = 0; ecmd = 0; eto = 0;
        if (op == 1) begin
            ere = (nd + 1 < words) ? nd + 1 : words;
            eto = (l > TIMEOUT) ? ere : 0;
        end else if (op == 2) begin
            ewe = (nd < words) ? nd : words;
        end else begin
            ecmd = 1;
        end
    endtask

    // Master side of one chip-select frame: command, 2 address bytes, nd data bytes.
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input int nd, input int l);
        int words;
        int nre;
        int t;
        words = int'(cmd[3:0]) + 1;
        lat   = l;
        clear_capture();
        cs_active = 1'b1;
        step();
        send(cmd);
        idle($urandom_range(1, 3));
        send(addr[15:8]);
        idle($urandom_range(1, 3));
        send(addr[7:0]);
        if (cmd[7:4] == 4'd1) begin
            nre = (nd + 1 < words) ? nd + 1 : words;
            for (int i = 0; i < nre; i++) begin
                t = 0;
                while (tx_q.size() <= i && t < 60) begin
                    step();
                    t++;
                end
                if (tx_q.size() <= i) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_wait word=%0d actual=no_tx_load required=tx_load_within_60_cycles", i);
                    break;
                end
                if (i < nd) begin
                    idle($urandom_range(2, 4));
                    send(8'($urandom));
                end
            end
        end else begin
            for (int i = 0; i < nd; i++) begin
                idle($urandom_range(1, 3));
                send(wdat[i]);
            end
        end
        idle($urandom_range(1, 3));
        check("busy_before_cs_drop", int'(busy), 1);
        cs_active = 1'b0;
        step();
        check("busy_after_cs_drop", int'(busy), 0);
        idle(1);
    endtask

    task automatic check_frame(input logic [7:0] cmd, input logic [15:0] addr, input int nd,
                               input int l, input int ewe, input int ere,
                               input int ecmd, input int eto);
        check("we_count", we_addr_q.size(), ewe);
        check("re_count", re_q.size(), ere);
        check("tx_count", tx_q.size(), ere);
        check("err_cmd_count", n_cmd, ecmd);
        check("err_timeout_count", n_to, eto);
        for (int i = 0; i < ewe && i < we_addr_q.size(); i++) begin
            check("we_addr", we_addr_q[i], (int'(addr) + i) % 65536);
            check("we_data", we_data_q[i], int'(wdat[i]));
        end
        for (int i = 0; i < ere && i < re_q.size(); i++) begin
            check("re_addr", re_q[i], (int'(addr) + i) % 65536);
        end
        for (int i = 0; i < ere && i < tx_q.size() && i < re_q.size(); i++) begin
            check("tx_data", tx_q[i], (l > TIMEOUT) ? 255 : int'(resp(i)));
            check("tx_latency", tx_cyc_q[i] - re_cyc_q[i], (l > TIMEOUT) ? TIMEOUT + 1 : l + 1);
        end
        $display("frame cmd=%02h addr=%04h nd=%0d lat=%0d we=%0d re=%0d tx=%0d err_cmd=%0d err_to=%0d",
                 cmd, addr, nd, l, we_addr_q.size(), re_q.size(), tx_q.size(), n_cmd, n_to);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t        vt [12];
        vec_t        v;
        logic [7:0]  cmd;
        logic [15:0] a;
        int          nd, l, op, words, ewe, ere, ecmd, eto, r;

        vt[0]  = '{8'h20, 16'h1234, 1,  2,  1, 0,  0, 0};
        vt[1]  = '{8'h12, 16'hFFFE, 3,  2,  0, 3,  0, 0};
        vt[2]  = '{8'h53, 16'h0000, 3,  2,  0, 0,  1, 0};
        vt[3]  = '{8'h10, 16'h0040, 1,  16, 0, 1,  0, 1};
        vt[4]  = '{8'h23, 16'h0100, 2,  2,  2, 0,  0, 0};
        vt[5]  = '{8'h1F, 16'h7FF0, 16, 1,  0, 16, 0, 0};
        vt[6]  = '{8'h10, 16'h0005, 1,  15, 0, 1,  0, 0};
        vt[7]  = '{8'h21, 16'hFFFF, 3,  2,  2, 0,  0, 0};
        vt[8]  = '{8'h00, 16'h1111, 2,  2,  0, 0,  1, 0};
        vt[9]  = '{8'hF0, 16'h2222, 0,  2,  0, 0,  1, 0};
        vt[10] = '{8'h14, 16'h0010, 2,  17, 0, 3,  0, 3};
        vt[11] = '{8'h10, 16'hABCD, 0,  3,  0, 1,  0, 0};

        rst        = 1'b1;
        cs_active  = 1'b0;
        rx_done    = 1'b0;
        rx_data    = 8'h00;
        reg_rvalid = 1'b0;
        reg_rdata  = 8'h00;
        lat        = 2;
        pend_cnt   = 0;
        pend_idx   = 0;
        salt       = 8'h00;
        for (int i = 0; i < 32; i++) wdat[i] = 8'(8'hAB + i * 17);

        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        for (int k = 0; k < 12; k++) begin
            v = vt[k];
            run_frame(v.cmd, v.addr, v.nd, v.lat);
            check_frame(v.cmd, v.addr, v.nd, v.lat, v.ewe, v.ere, v.ecmd, v.eto);
        end

        // Reset while a read is waiting on the register file.
        clear_capture();
        lat       = 17;
        cs_active = 1'b1;
        step();
        send(8'h13);
        idle(1);
        send(8'h00);
        idle(1);
        send(8'h40);
        idle(3);
        check("mid_rst_re_seen", re_q.size(), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("mid_rst");
        pend_cnt  = 0;
        cs_active = 1'b0;
        idle(2);
        v = vt[0];
        run_frame(v.cmd, v.addr, v.nd, v.lat);
        check_frame(v.cmd, v.addr, v.nd, v.lat, v.ewe, v.ere, v.ecmd, v.eto);

        for (int f = 0; f < 40; f++) begin
            salt = 8'($urandom);
            for (int i = 0; i < 32; i++) wdat[i] = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                op = 1;
            end else if (r < 8) begin
                op = 2;
            end else begin
                op = $urandom_range(2, 15);
                if (op == 2) op = 0;
            end
            cmd   = {4'(op), 4'($urandom_range(0, 15))};
            words = int'(cmd[3:0]) + 1;
            a     = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(16'hFFF0 + $urandom_range(0, 15));
            l     = $urandom_range(1, 17);
            if (op == 1) nd = $urandom_range(0, words);
            else if (op == 2) nd = $urandom_range(0, words + 1);
            else nd = $urandom_range(0, 3);
            model(cmd, nd, l, ewe, ere, ecmd, eto);
            run_frame(cmd, a, nd, l);
            check_frame(cmd, a, nd, l, ewe, ere, ecmd, eto);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
